// File: rtl/cycle_det_pkg.sv
// Shared types and helpers for the cycle detector: FSM states, ring-mode
// selectors and the wrap-aware cycle length calculation.
package cycle_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        RESULT,
        HALT
    } state_t;

    localparam int RING_STOP      = 0;
    localparam int RING_OVERWRITE = 1;

    // Distance from the matched slot forward to the write pointer; zero means a full lap.
    function automatic int cyc_len_mod(input int wr, input int m, input int depth);
        int d;
        d = (wr - m + depth) % depth;
        return (d == 0) ? depth : d;
    endfunction

endpackage

// File: rtl/cycle_hist_mem.sv
// History storage: DEPTH x WIDTH array with a clocked write port and a
// combinational read port. Contents are not reset.
module cycle_hist_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cycle_detector.sv
// Loop/livelock monitor: records status words and reports the first repeat
// with its history slot and the cycle length, or overflow when history fills.
module cycle_detector
    import cycle_det_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int RING  = 0,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] status,
    output logic             done,
    output logic             cycle_found,
    output logic [IDX_W-1:0] match_idx,
    output logic [IDX_W:0]   cycle_len,
    output logic [IDX_W:0]   hist_count,
    output logic             overflow
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    state_t           state;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] rdata;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cmp_cnt;
    logic             hit;
    logic             full;
    logic             we;

    assign full     = (hist_count == FULL_COUNT);
    assign in_ready = (state == IDLE) && !clear;
    assign we       = (state == RESULT) && !clear && !hit && (!full || RING == RING_OVERWRITE);

    cycle_hist_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(cand),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cand        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cmp_cnt     <= '0;
            hit         <= 1'b0;
            done        <= 1'b0;
            cycle_found <= 1'b0;
            match_idx   <= '0;
            cycle_len   <= '0;
            hist_count  <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cmp_cnt     <= '0;
            hit         <= 1'b0;
            done        <= 1'b0;
            cycle_found <= 1'b0;
            match_idx   <= '0;
            cycle_len   <= '0;
            hist_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cand    <= status;
                        // Once wrapped, the oldest entry sits at the write pointer.
                        rd_ptr  <= full ? wr_ptr : '0;
                        cmp_cnt <= '0;
                        hit     <= 1'b0;
                        state   <= (hist_count != '0) ? SEARCH : RESULT;
                    end
                end
                SEARCH: begin
                    if (rdata == cand) begin
                        hit       <= 1'b1;
                        match_idx <= rd_ptr;
                        state     <= RESULT;
                    end else if (cmp_cnt + 1'b1 == hist_count) begin
                        state <= RESULT;
                    end else begin
                        rd_ptr  <= rd_ptr + 1'b1;
                        cmp_cnt <= cmp_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    done <= 1'b1;
                    if (hit) begin
                        cycle_found <= 1'b1;
                        cycle_len   <= CNT_W'(cyc_len_mod(int'(wr_ptr), int'(match_idx), DEPTH));
                        state       <= HALT;
                    end else if (!full) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        hist_count <= hist_count + 1'b1;
                        state      <= IDLE;
                    end else if (RING == RING_STOP) begin
                        overflow <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= IDLE;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_detector.sv
// Scoreboard bench for cycle_detector: one stop-mode and one ring-mode
// instance (WIDTH=8, DEPTH=4) driven with directed words and hand-computed results.
module tb_cycle_detector;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
        logic [2:0] len;
        logic [2:0] hc;
        logic       ovf;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clear     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] status    [2];
    logic       done      [2];
    logic       cycle_found [2];
    logic [1:0] match_idx [2];
    logic [2:0] cycle_len [2];
    logic [2:0] hist_count [2];
    logic       overflow  [2];

    int   checks   = 0;
    int   failures = 0;
    int   neg_cnt  = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    cycle_detector #(.WIDTH(8), .DEPTH(4), .RING(0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .status(status[0]), .done(done[0]),
        .cycle_found(cycle_found[0]), .match_idx(match_idx[0]), .cycle_len(cycle_len[0]),
        .hist_count(hist_count[0]), .overflow(overflow[0])
    );

    cycle_detector #(.WIDTH(8), .DEPTH(4), .RING(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .status(status[1]), .done(done[1]),
        .cycle_found(cycle_found[1]), .match_idx(match_idx[1]), .cycle_len(cycle_len[1]),
        .hist_count(hist_count[1]), .overflow(overflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [1:0] i, input logic [2:0] l,
                                input logic [2:0] h, input logic o, input int lat);
        exp_t e;
        e.found = f; e.idx = i; e.len = l; e.hc = h; e.ovf = o; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    task automatic applyStimulus(input int d, input logic [7:0] w, input bit expect_done, input exp_t e);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        status[d]   = w;
        #1;
        while (!in_ready[d] && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready[d]) begin
            checkOutput($sformatf("dut%0d_handshake_timeout", d), 32'(in_ready[d]), 32'd1);
            in_valid[d] = 1'b0;
            return;
        end
        if (expect_done) begin
            e.acc = neg_cnt;
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic waitDrain(input int d);
        int guard;
        guard = 0;
        while (((d == 0) ? sb0.size() : sb1.size()) != 0 && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (((d == 0) ? sb0.size() : sb1.size()) != 0)
            checkOutput($sformatf("dut%0d_done_timeout", d), 32'(guard), 32'd0);
    endtask

    task automatic doClear(input int d, input logic offer);
        @(negedge clk);
        clear[d]    = 1'b1;
        in_valid[d] = offer;
        status[d]   = 8'h99;
        #1;
        checkOutput($sformatf("dut%0d_in_ready_during_clear", d), 32'(in_ready[d]), 32'd0);
        @(negedge clk);
        clear[d]    = 1'b0;
        in_valid[d] = 1'b0;
        #1;
        checkOutput($sformatf("dut%0d_clr_found", d), 32'(cycle_found[d]), 32'd0);
        checkOutput($sformatf("dut%0d_clr_ovf", d), 32'(overflow[d]), 32'd0);
        checkOutput($sformatf("dut%0d_clr_hc", d), 32'(hist_count[d]), 32'd0);
        checkOutput($sformatf("dut%0d_clr_len", d), 32'(cycle_len[d]), 32'd0);
        checkOutput($sformatf("dut%0d_clr_ready", d), 32'(in_ready[d]), 32'd1);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_cnt++;
            for (int d = 0; d < 2; d++) begin
                if (done[d] === 1'b1) begin
                    if (((d == 0) ? sb0.size() : sb1.size()) == 0) begin
                        checkOutput($sformatf("dut%0d_spurious_done", d), 32'd1, 32'd0);
                    end else begin
                        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                        checkOutput($sformatf("dut%0d_latency", d), 32'(neg_cnt - e.acc), 32'(e.lat));
                        checkOutput($sformatf("dut%0d_found", d), 32'(cycle_found[d]), 32'(e.found));
                        checkOutput($sformatf("dut%0d_match_idx", d), 32'(match_idx[d]), 32'(e.idx));
                        checkOutput($sformatf("dut%0d_cycle_len", d), 32'(cycle_len[d]), 32'(e.len));
                        checkOutput($sformatf("dut%0d_hist_count", d), 32'(hist_count[d]), 32'(e.hc));
                        checkOutput($sformatf("dut%0d_overflow", d), 32'(overflow[d]), 32'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            clear[d] = 1'b0; in_valid[d] = 1'b0; status[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("rst_done", 32'(done[0]), 32'd0);
        checkOutput("rst_found", 32'(cycle_found[0]), 32'd0);
        checkOutput("rst_hc", 32'(hist_count[0]), 32'd0);
        checkOutput("rst_ovf", 32'(overflow[0]), 32'd0);
        checkOutput("rst_len", 32'(cycle_len[0]), 32'd0);

        $display("[TB] repeat after three distinct words");
        applyStimulus(0, 8'h11, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        applyStimulus(0, 8'h22, 1, mk(0, 2'd0, 3'd0, 3'd2, 0, 3));
        applyStimulus(0, 8'h33, 1, mk(0, 2'd0, 3'd0, 3'd3, 0, 4));
        applyStimulus(0, 8'h22, 1, mk(1, 2'd1, 3'd2, 3'd3, 0, 4));
        waitDrain(0);
        @(negedge clk); #1;
        checkOutput("halt_in_ready", 32'(in_ready[0]), 32'd0);

        $display("[TB] clear in halt with a word offered");
        doClear(0, 1'b1);
        applyStimulus(0, 8'h11, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        waitDrain(0);

        $display("[TB] immediate repeat");
        doClear(0, 1'b0);
        applyStimulus(0, 8'hA0, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        applyStimulus(0, 8'hA0, 1, mk(1, 2'd0, 3'd1, 3'd1, 0, 3));
        waitDrain(0);

        $display("[TB] overflow in stop mode");
        doClear(0, 1'b0);
        applyStimulus(0, 8'h01, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        applyStimulus(0, 8'h02, 1, mk(0, 2'd0, 3'd0, 3'd2, 0, 3));
        applyStimulus(0, 8'h03, 1, mk(0, 2'd0, 3'd0, 3'd3, 0, 4));
        applyStimulus(0, 8'h04, 1, mk(0, 2'd0, 3'd0, 3'd4, 0, 5));
        applyStimulus(0, 8'h05, 1, mk(0, 2'd0, 3'd0, 3'd4, 1, 6));
        waitDrain(0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("ovf_in_ready", 32'(in_ready[0]), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow[0]), 32'd1);

        $display("[TB] ring mode overwrite");
        applyStimulus(1, 8'h01, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        applyStimulus(1, 8'h02, 1, mk(0, 2'd0, 3'd0, 3'd2, 0, 3));
        applyStimulus(1, 8'h03, 1, mk(0, 2'd0, 3'd0, 3'd3, 0, 4));
        applyStimulus(1, 8'h04, 1, mk(0, 2'd0, 3'd0, 3'd4, 0, 5));
        applyStimulus(1, 8'h05, 1, mk(0, 2'd0, 3'd0, 3'd4, 0, 6));
        applyStimulus(1, 8'h01, 1, mk(0, 2'd0, 3'd0, 3'd4, 0, 6));
        applyStimulus(1, 8'h03, 1, mk(1, 2'd2, 3'd4, 3'd4, 0, 3));
        waitDrain(1);

        $display("[TB] reset during search");
        doClear(0, 1'b0);
        applyStimulus(0, 8'h11, 1, mk(0, 2'd0, 3'd0, 3'd1, 0, 2));
        applyStimulus(0, 8'h22, 1, mk(0, 2'd0, 3'd0, 3'd2, 0, 3));
        applyStimulus(0, 8'h33, 1, mk(0, 2'd0, 3'd0, 3'd3, 0, 4));
        waitDrain(0);
        applyStimulus(0, 8'h44, 0, mk(0, 2'd0, 3'd0, 3'd0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_done", 32'(done[0]), 32'd0);
        checkOutput("midrst_hc", 32'(hist_count[0]), 32'd0);
        checkOutput("midrst_found", 32'(cycle_found[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("midrst_ovf", 32'(overflow[0]), 32'd0);
        checkOutput("midrst_idx", 32'(match_idx[0]), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        checkOutput("midrst_hc_after", 32'(hist_count[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
